// File: rtl/alu_op_ctrl_pkg.sv
// Shared definitions for the ALU controller and the ALU execution units.
package alu_op_ctrl_pkg;

    // Controller state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Unit-select field, fun[3:2]
    localparam logic [1:0] ALU_ARITH = 2'b00;
    localparam logic [1:0] ALU_LOGIC = 2'b01;
    localparam logic [1:0] ALU_CMP   = 2'b10;
    localparam logic [1:0] ALU_SHIFT = 2'b11;

    // Logic unit opcodes
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_NOR = 4'b0111;

    // One-hot unit enable, bit order {shift, cmp, logic, arith}
    function automatic logic [3:0] unit_dec(input logic [1:0] sel);
        logic [3:0] en;
        en = 4'b0000;
        case (sel)
            ALU_ARITH: en = 4'b0001;
            ALU_LOGIC: en = 4'b0010;
            ALU_CMP:   en = 4'b0100;
            ALU_SHIFT: en = 4'b1000;
            default:   en = 4'b0000;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/alu_op_ctrl.sv
// Initiator side of the ALU unit interface: takes one request, pulses the
// selected unit for one cycle, waits for its flag (or times out) and returns
// the captured result over a valid/ready response port.
module alu_op_ctrl
    import alu_op_ctrl_pkg::*;
#(
    parameter int width   = 16,
    parameter int TIMEOUT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [width-1:0] req_a,
    input  logic [width-1:0] req_b,
    input  logic [3:0]       req_fun,
    output logic [width-1:0] alu_a,
    output logic [width-1:0] alu_b,
    output logic [3:0]       alu_fun,
    output logic             arith_en,
    output logic             logic_en,
    output logic             cmp_en,
    output logic             shift_en,
    input  logic [width-1:0] alu_res,
    input  logic             alu_flag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [width-1:0] rsp_data,
    output logic [3:0]       rsp_fun,
    output logic             rsp_err
);

    // Counter wide enough to hold TIMEOUT itself
    localparam int            CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    // Value seen on the last permitted WAIT cycle
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [3:0]         r_en;
    logic [width-1:0]   r_alu_a;
    logic [width-1:0]   r_alu_b;
    logic [3:0]         r_alu_fun;
    logic               r_rsp_valid;
    logic [width-1:0]   r_rsp_data;
    logic [3:0]         r_rsp_fun;
    logic               r_rsp_err;
    logic               w_cnt_done;

    assign req_ready  = (r_state == ST_IDLE);
    assign w_cnt_done = (r_cnt == CNT_LAST);

    assign {shift_en, cmp_en, logic_en, arith_en} = r_en;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_fun   = r_alu_fun;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_fun   = r_rsp_fun;
    assign rsp_err   = r_rsp_err;

    // Control FSM: issue, wait for flag or timeout, hold response until taken
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_en        <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_fun   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_fun   <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_alu_a   <= req_a;
                        r_alu_b   <= req_b;
                        r_alu_fun <= req_fun;
                        r_en      <= unit_dec(req_fun[3:2]);
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Unit registers its result at the end of this cycle
                    r_en    <= '0;
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (alu_flag) begin
                        r_rsp_data  <= alu_res;
                        r_rsp_fun   <= r_alu_fun;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                        // Undefined unit codes never raise the flag and land here
                        if (w_cnt_done) begin
                            r_rsp_data  <= '0;
                            r_rsp_fun   <= r_alu_fun;
                            r_rsp_err   <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_ctrl.sv
// Bench for alu_op_ctrl: ALU unit model, transaction-level reference model
// checked every cycle, directed scenarios and randomized traffic.
module tb_alu_op_ctrl;
    import alu_op_ctrl_pkg::*;

    localparam int W  = 16;
    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic [3:0]   req_fun = '0;
    logic [W-1:0] alu_a, alu_b;
    logic [3:0]   alu_fun;
    logic         arith_en, logic_en, cmp_en, shift_en;
    logic [W-1:0] alu_res;
    logic         alu_flag;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_data;
    logic [3:0]   rsp_fun;
    logic         rsp_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic force_noflag = 1'b0;
    int en_cnt[4];

    alu_op_ctrl #(.width(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_fun(req_fun),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
        .arith_en(arith_en), .logic_en(logic_en), .cmp_en(cmp_en), .shift_en(shift_en),
        .alu_res(alu_res), .alu_flag(alu_flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_fun(rsp_fun), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Function of every unit; MSB says whether the code is defined
    function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [3:0] f);
        case (f)
            4'b0000: return {1'b1, a + b};
            4'b0001: return {1'b1, a - b};
            4'b0100: return {1'b1, a & b};
            4'b0101: return {1'b1, a | b};
            4'b0110: return {1'b1, a ^ b};
            4'b0111: return {1'b1, ~(a | b)};
            4'b1000: return {1'b1, W'(a == b)};
            4'b1001: return {1'b1, W'($signed(a) < $signed(b))};
            4'b1100: return {1'b1, a << b[3:0]};
            4'b1101: return {1'b1, a >> b[3:0]};
            default: return {1'b0, {W{1'b0}}};
        endcase
    endfunction

    // ALU units: registered result and flag one edge after the enable
    logic [W:0] u_r;
    always @(posedge clk) begin
        if (arith_en | logic_en | cmp_en | shift_en) begin
            u_r = ref_op(alu_a, alu_b, alu_fun);
            alu_res  <= u_r[W] ? u_r[W-1:0] : '0;
            alu_flag <= u_r[W] && !force_noflag;
        end else begin
            alu_res  <= '0;
            alu_flag <= 1'b0;
        end
    end

    // Transaction model: accept period c, enable in c+1, response from c+lat
    bit           m_busy = 0;
    int           m_acc, m_lat, m_t;
    logic [W-1:0] m_a, m_b, m_data;
    logic [3:0]   m_fun, m_en;
    logic         m_err;
    logic [W:0]   m_r;
    bit           e_rv;

    always @(negedge clk) begin
        if (!rst) begin
            m_busy = 0;
            chk("rst_req_ready", req_ready, 1);
            chk("rst_en", {shift_en, cmp_en, logic_en, arith_en}, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp", {rsp_data, rsp_fun, rsp_err}, 0);
            chk("rst_alu", {alu_a, alu_b, alu_fun}, 0);
        end else begin
            m_t  = cyc - m_acc;
            e_rv = m_busy && (m_t >= m_lat);
            chk("cyc_req_ready", req_ready, !m_busy);
            chk("cyc_en", {shift_en, cmp_en, logic_en, arith_en},
                (m_busy && m_t == 1) ? m_en : 4'b0000);
            chk("cyc_rsp_valid", rsp_valid, e_rv);
            if (m_busy && m_t >= 1 && m_t < m_lat)
                chk("cyc_alu_ops", {alu_a, alu_b, alu_fun}, {m_a, m_b, m_fun});
            if (e_rv)
                chk("cyc_rsp", {rsp_data, rsp_fun, rsp_err}, {m_data, m_fun, m_err});
            if (e_rv && rsp_ready) begin
                m_busy = 0;
            end else if (!m_busy && req_valid) begin
                m_busy = 1;
                m_acc  = cyc;
                m_a    = req_a;
                m_b    = req_b;
                m_fun  = req_fun;
                m_r    = ref_op(req_a, req_b, req_fun);
                m_err  = !(m_r[W] && !force_noflag);
                m_data = m_err ? '0 : m_r[W-1:0];
                m_lat  = m_err ? 2 + TO : 3;
                m_en   = 4'b0001 << req_fun[3:2];
            end
        end
    end

    // One directed operation with literal expectations; lat is counted from E0
    task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] f, input int hold, input logic [W-1:0] exp_d,
                          input logic exp_e, input int exp_lat, input logic [3:0] exp_en);
        int n, e0;
        logic [W-1:0] d;
        logic [3:0] fn;
        logic er;
        for (int i = 0; i < 4; i++) en_cnt[i] = 0;
        @(posedge clk); #1;
        req_a = a; req_b = b; req_fun = f; req_valid = 1'b1;
        rsp_ready = (hold == 0);
        n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk({nm, "_accept"}, n < 50, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        e0 = cyc;
        n = 0;
        while (!rsp_valid && n < 40) begin
            if (arith_en) en_cnt[0]++;
            if (logic_en) en_cnt[1]++;
            if (cmp_en)   en_cnt[2]++;
            if (shift_en) en_cnt[3]++;
            @(posedge clk); #1; n++;
        end
        chk({nm, "_rsp_seen"}, rsp_valid, 1);
        chk({nm, "_lat"}, cyc - e0, exp_lat);
        chk({nm, "_data"}, rsp_data, exp_d);
        chk({nm, "_err"}, rsp_err, exp_e);
        chk({nm, "_fun"}, rsp_fun, f);
        for (int i = 0; i < 4; i++)
            chk({nm, "_en_pulses"}, en_cnt[i], exp_en[i] ? 1 : 0);
        d = rsp_data; fn = rsp_fun; er = rsp_err;
        for (int i = 0; i < hold - 1; i++) begin
            @(posedge clk); #1;
            chk({nm, "_hold_valid"}, rsp_valid, 1);
            chk({nm, "_hold_stable"}, {rsp_data, rsp_fun, rsp_err}, {d, fn, er});
            chk({nm, "_hold_req_ready"}, req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk({nm, "_done_valid"}, rsp_valid, 0);
        chk({nm, "_done_req_ready"}, req_ready, 1);
    endtask

    initial begin
        // Pin the reference function itself
        chk("ref_and", ref_op(16'h00F0, 16'h0FF0, 4'b0100), {1'b1, 16'h00F0});
        chk("ref_nor", ref_op(16'h0000, 16'h00FF, 4'b0111), {1'b1, 16'hFF00});
        chk("ref_slt", ref_op(16'hFFFF, 16'h0001, 4'b1001), {1'b1, 16'h0001});
        chk("ref_undef", ref_op(16'h1234, 16'h5678, 4'b1110), {1'b0, 16'h0000});

        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        run_op("and", 16'h00F0, 16'h0FF0, 4'b0100, 0, 16'h00F0, 1'b0, 2, 4'b0010);
        run_op("nor", 16'h0000, 16'h00FF, 4'b0111, 0, 16'hFF00, 1'b0, 2, 4'b0010);
        run_op("bp_or", 16'h1200, 16'h0034, 4'b0101, 5, 16'h1234, 1'b0, 2, 4'b0010);
        force_noflag = 1'b1;
        run_op("timeout", 16'h00F0, 16'h0FF0, 4'b0100, 0, 16'h0000, 1'b1, 1 + TO, 4'b0010);
        force_noflag = 1'b0;
        run_op("dec_arith", 16'h0003, 16'h0004, 4'b0000, 0, 16'h0007, 1'b0, 2, 4'b0001);
        run_op("dec_cmp", 16'h0005, 16'h0005, 4'b1000, 0, 16'h0001, 1'b0, 2, 4'b0100);
        run_op("dec_shift", 16'h0001, 16'h0004, 4'b1100, 0, 16'h0010, 1'b0, 2, 4'b1000);
        run_op("undef_code", 16'h0001, 16'h0002, 4'b1011, 0, 16'h0000, 1'b1, 1 + TO, 4'b0100);

        // Reset during the ISSUE cycle
        @(posedge clk); #1;
        req_a = 16'h00F0; req_b = 16'h0FF0; req_fun = 4'b0100; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("midrst_issue_en", logic_en, 1);
        #1 rst = 1'b0;
        #1 chk("midrst_async_en", {shift_en, cmp_en, logic_en, arith_en}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_rsp", rsp_valid, 0);
            chk("midrst_req_ready", req_ready, 1);
        end
        run_op("post_rst", 16'h0F0F, 16'h00FF, 4'b0110, 0, 16'h0FF0, 1'b0, 2, 4'b0010);

        // Random traffic checked by the per-cycle model
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            req_valid = ($urandom_range(0, 2) != 0);
            req_a     = W'($urandom);
            req_b     = W'($urandom);
            req_fun   = 4'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1 chk("drain_idle", req_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_op_ctrl.md
Name: alu_op_ctrl

Overview:
- Initiator side of the ALU unit interface. Accepts one operation request over a valid/ready handshake and decodes alu_fun to a single unit enable.
- Drives operands, alu_fun and the enable to the ALU execution units (arithmetic, logic, compare, shift) for exactly one cycle.
- Waits for the selected unit's registered flag, captures the registered result, and returns it over a valid/ready response port.
- Sits between the system-level command source and the ALU units.

Parameters:
- width, 16: operand and result width in bits.
- TIMEOUT, 4: WAIT cycles allowed for the unit flag before an error response (minimum 1).

Ports:
- clk  input  1  clock; all registers on rising edge.
- rst  input  1  asynchronous reset, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  high only in IDLE.
- req_a  input  width  operand A (signed).
- req_b  input  width  operand B (signed).
- req_fun  input  4  ALU function code.
- alu_a  output  width  registered operand A to the units.
- alu_b  output  width  registered operand B to the units.
- alu_fun  output  4  registered function code to the units.
- arith_en, logic_en, cmp_en, shift_en  output  1 each  registered unit enables; one-hot or all zero.
- alu_res  input  width  OR of the units' registered results; disabled units output 0.
- alu_flag  input  1  OR of the units' registered flags.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  downstream accepts the response.
- rsp_data  output  width  captured result; 0 on error.
- rsp_fun  output  4  function code of the completed operation.
- rsp_err  output  1  timeout: no flag seen.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - alu_a, alu_b, alu_fun, all enables, rsp_valid, rsp_data, rsp_fun, rsp_err and the timeout counter go to 0.
  - Reset mid-operation abandons the operation immediately: enables drop and any pending response is discarded.
- Unit decode from req_fun[3:2]: 00 arith_en, 01 logic_en, 10 cmp_en, 11 shift_en.
- States: IDLE, ISSUE, WAIT, RESP (2-bit encoding).
- IDLE:
  - req_ready = 1, decoded from state, not registered.
  - On req_valid: latch req_a, req_b and req_fun into alu_a, alu_b and alu_fun; set the decoded enable; go to ISSUE.
- ISSUE:
  - Exactly one cycle with the enable high; the units register their result at the end of this cycle.
  - Clear the enable and the counter; go to WAIT.
- WAIT:
  - alu_a, alu_b and alu_fun stay stable; all enables are 0.
  - If alu_flag = 1: capture alu_res into rsp_data, alu_fun into rsp_fun, set rsp_err = 0; go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT: rsp_data = 0, rsp_err = 1, rsp_fun = alu_fun; go to RESP.
  - An undefined code inside a unit (for example logic unit codes outside 0100–0111) must resolve through this timeout path.
- RESP:
  - rsp_valid = 1. rsp_data, rsp_fun and rsp_err stay stable until rsp_valid && rsp_ready.
  - On that handshake clear rsp_valid and go to IDLE. A new request is not accepted in the same cycle.
- Latency, with a normal unit and rsp_ready held high:
  - Acceptance edge E0, then ISSUE cycle, then WAIT cycle (flag visible), then RESP cycle.
  - rsp_valid is high from edge E0+2 for one cycle. Minimum 4 cycles per operation.
- Stale data: units output 0 when disabled, so the flag only appears in the first WAIT cycle for single-cycle units. The controller never samples alu_res outside WAIT.
- Arithmetic: the controller passes data unmodified; no sign extension or truncation.

Decomposition:
- Shared package, also used by the ALU units:
  - State encoding constants.
  - Unit-select field constants (ALU_ARITH=2'b00, ALU_LOGIC=2'b01, ALU_CMP=2'b10, ALU_SHIFT=2'b11).
  - Logic opcodes 0100–0111.
- No sub-module: the decode is a small case inside this block; the counter is inline.

Test Plan:
- AND: req a=16'h00F0, b=16'h0FF0, fun=4'b0100, with the logic unit model attached.
  - Expect logic_en high for exactly 1 cycle.
  - Expect rsp_valid at E0+2 with rsp_data=16'h00F0, rsp_err=0, rsp_fun=4'b0100.
- NOR: fun=4'b0111, a=16'h0000, b=16'h00FF -> rsp_data=16'hFF00.
- Backpressure: rsp_ready held low 5 cycles after rsp_valid -> data, fun and err stable; req_ready=0 throughout; completes on the first rsp_ready cycle.
- Timeout: fun=4'b0100 with unit flag forced 0 -> rsp_valid after ISSUE + 4 WAIT cycles; rsp_err=1, rsp_data=0.
- Decode: fun=4'b0000, 4'b1000, 4'b1100 -> only arith_en, cmp_en, shift_en respectively pulse for one cycle; the others stay 0.
- Reset mid-op: assert rst low during the ISSUE cycle -> enables go to 0 asynchronously; no response ever appears; after release req_ready=1 and a new request completes normally.
